// File: rtl/ps_merge_arbiter_pkg.sv
// Shared definitions for the PS-stage two-way merge arbiter.
// Holds the packet width, packet field positions and the channel identifiers
// used by the arbiter top and its input slots.
package ps_merge_arbiter_pkg;

  // Packet width seen by the PS stage.
  localparam int unsigned PktWidth = 52;

  // Packet field ranges.
  localparam int unsigned DestMsb   = 51;
  localparam int unsigned DestLsb   = 40;
  localparam int unsigned OpcodeMsb = 39;
  localparam int unsigned OpcodeLsb = 32;

  // Channel identifiers: ch0 = matching-stage return, ch1 = host inject.
  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  // Winner among the valid slots. Only meaningful when at least one is valid.
  function automatic ch_e pick_winner(logic v0, logic v1, ch_e last, logic prio_ch1);
    ch_e win;
    if (v0 && v1) begin
      if (prio_ch1) win = CH1;
      else          win = (last == CH0) ? CH1 : CH0;
    end else if (v1) begin
      win = CH1;
    end else begin
      win = CH0;
    end
    return win;
  endfunction

endpackage

// File: rtl/ps_merge_slot.sv
// One-entry input buffer for one merge channel.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   send_i  upstream packet valid
//   data_i  upstream packet
//   grant_i this slot is being forwarded this cycle
//   ack_o   slot can take a packet (empty, or draining this cycle)
//   valid_o slot holds a packet
//   data_o  held packet
module ps_merge_slot
  import ps_merge_arbiter_pkg::*;
#(
  parameter int unsigned Width = PktWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             send_i,
  input  logic [Width-1:0] data_i,
  input  logic             grant_i,
  output logic             ack_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             accept;

  always_comb begin
    // Ready depends only on held state and the grant, never on send_i.
    ack_o   = ~valid_q | grant_i;
    accept  = send_i & ack_o;
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      // Covers refill: drained and reloaded on the same edge.
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (grant_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ps_merge_arbiter.sv
// Two-way packet merge arbiter feeding the PS stage.
// Each channel is buffered in a one-entry slot; one slot per cycle is moved
// into the output register by round-robin (or ch1-first when PRIO_CH1 = 1).
// Ports:
//   CP, MR                  clock (rising edge), synchronous active-high reset
//   Send_inK/PACKET_INK     channel K packet valid / data
//   Ack_outK                channel K ready
//   Send_out/PACKET_OUT     merged packet valid / data toward the PS stage
//   Ack_in                  PS stage ready
//   gnt_cnt0/gnt_cnt1       saturating per-channel forward counters
//   last_gnt                channel of the most recent grant
module ps_merge_arbiter
  import ps_merge_arbiter_pkg::*;
#(
  parameter int unsigned PKT_W    = PktWidth,
  parameter int unsigned CNT_W    = 16,
  parameter bit          PRIO_CH1 = 1'b0
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             Send_in0,
  input  logic [PKT_W-1:0] PACKET_IN0,
  output logic             Ack_out0,
  input  logic             Send_in1,
  input  logic [PKT_W-1:0] PACKET_IN1,
  output logic             Ack_out1,
  output logic             Send_out,
  output logic [PKT_W-1:0] PACKET_OUT,
  input  logic             Ack_in,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic             last_gnt
);

  logic             valid0, valid1;
  logic [PKT_W-1:0] data0, data1;
  logic             gnt0, gnt1;
  logic             out_free;
  ch_e              win;

  logic             send_q, send_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  ch_e              last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  ps_merge_slot #(
    .Width (PKT_W)
  ) u_slot0 (
    .clk_i   (CP),
    .rst_i   (MR),
    .send_i  (Send_in0),
    .data_i  (PACKET_IN0),
    .grant_i (gnt0),
    .ack_o   (Ack_out0),
    .valid_o (valid0),
    .data_o  (data0)
  );

  ps_merge_slot #(
    .Width (PKT_W)
  ) u_slot1 (
    .clk_i   (CP),
    .rst_i   (MR),
    .send_i  (Send_in1),
    .data_i  (PACKET_IN1),
    .grant_i (gnt1),
    .ack_o   (Ack_out1),
    .valid_o (valid1),
    .data_o  (data1)
  );

  // Arbitration: at most one grant, only when the output register can load.
  always_comb begin
    out_free = ~send_q | Ack_in;
    win      = pick_winner(valid0, valid1, last_q, PRIO_CH1);
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (out_free && (valid0 || valid1)) begin
      gnt0 = (win == CH0);
      gnt1 = (win == CH1);
    end
  end

  always_comb begin
    send_d = send_q;
    pkt_d  = pkt_q;
    last_d = last_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    // Current packet consumed (or register empty); reload below if granted.
    if (out_free) send_d = 1'b0;
    if (gnt0) begin
      send_d = 1'b1;
      pkt_d  = data0;
      last_d = CH0;
      if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
    end else if (gnt1) begin
      send_d = 1'b1;
      pkt_d  = data1;
      last_d = CH1;
      if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      send_q <= 1'b0;
      pkt_q  <= '0;
      last_q <= CH1;  // ch0 wins the first contest
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      send_q <= send_d;
      pkt_q  <= pkt_d;
      last_q <= last_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign Send_out   = send_q;
  assign PACKET_OUT = pkt_q;
  assign gnt_cnt0   = cnt0_q;
  assign gnt_cnt1   = cnt1_q;
  assign last_gnt   = last_q;

endmodule

// File: tb/tb_ps_merge_arbiter.sv
// Self-checking bench for ps_merge_arbiter: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model and a
// per-channel ordering scoreboard. A second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_ps_merge_arbiter;

  localparam int W = 52;

  logic         CP = 1'b0;
  logic         MR = 1'b1;
  logic         Send_in0 = 1'b0, Send_in1 = 1'b0, Ack_in = 1'b0;
  logic [W-1:0] PACKET_IN0 = '0, PACKET_IN1 = '0;

  logic         Ack_out0, Ack_out1, Send_out, last_gnt;
  logic [W-1:0] PACKET_OUT;
  logic [15:0]  gnt_cnt0, gnt_cnt1;

  logic         s_ack0, s_ack1, s_send, s_last;
  logic [W-1:0] s_pkt;
  logic [3:0]   s_cnt0, s_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 CP = ~CP;

  ps_merge_arbiter dut (
    .CP         (CP),
    .MR         (MR),
    .Send_in0   (Send_in0),
    .PACKET_IN0 (PACKET_IN0),
    .Ack_out0   (Ack_out0),
    .Send_in1   (Send_in1),
    .PACKET_IN1 (PACKET_IN1),
    .Ack_out1   (Ack_out1),
    .Send_out   (Send_out),
    .PACKET_OUT (PACKET_OUT),
    .Ack_in     (Ack_in),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1),
    .last_gnt   (last_gnt)
  );

  ps_merge_arbiter #(
    .CNT_W (4)
  ) dut_s (
    .CP         (CP),
    .MR         (MR),
    .Send_in0   (Send_in0),
    .PACKET_IN0 (PACKET_IN0),
    .Ack_out0   (s_ack0),
    .Send_in1   (Send_in1),
    .PACKET_IN1 (PACKET_IN1),
    .Ack_out1   (s_ack1),
    .Send_out   (s_send),
    .PACKET_OUT (s_pkt),
    .Ack_in     (Ack_in),
    .gnt_cnt0   (s_cnt0),
    .gnt_cnt1   (s_cnt1),
    .last_gnt   (s_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Reference model: slots and output register as queues, grants from the rules.
  logic [W-1:0] mb0[$], mb1[$], mout[$], sq0[$], sq1[$];
  logic [W-1:0] mpkt;
  int           mcnt0, mcnt1;
  bit           mlast, mready = 1'b0;

  initial begin
    bit           free, g, ch, eack0, eack1, s0, s1, ai, mr, dsend;
    logic [W-1:0] i0, i1, dpkt, nxt;
    forever begin
      @(negedge CP);
      #1;
      s0 = Send_in0; s1 = Send_in1; ai = Ack_in; mr = MR;
      i0 = PACKET_IN0; i1 = PACKET_IN1;
      dsend = Send_out; dpkt = PACKET_OUT;
      free = (mout.size() == 0) || ai;
      g    = free && (mb0.size() + mb1.size() != 0);
      if (mb0.size() != 0 && mb1.size() != 0) ch = ~mlast;
      else                                    ch = (mb1.size() != 0);
      eack0 = (mb0.size() == 0) || (g && !ch);
      eack1 = (mb1.size() == 0) || (g && ch);
      if (mready) begin
        chk("send_out", 64'(Send_out), 64'(mout.size() != 0));
        chk("packet_out", 64'(PACKET_OUT), 64'(mpkt));
        chk("ack_out0", 64'(Ack_out0), 64'(eack0));
        chk("ack_out1", 64'(Ack_out1), 64'(eack1));
        chk("gnt_cnt0", 64'(gnt_cnt0), 64'(sat(mcnt0, 65535)));
        chk("gnt_cnt1", 64'(gnt_cnt1), 64'(sat(mcnt1, 65535)));
        chk("last_gnt", 64'(last_gnt), 64'(mlast));
        chk("small_cnt0", 64'(s_cnt0), 64'(sat(mcnt0, 15)));
        chk("small_cnt1", 64'(s_cnt1), 64'(sat(mcnt1, 15)));
      end
      @(posedge CP);
      if (mr) begin
        mb0.delete(); mb1.delete(); mout.delete(); sq0.delete(); sq1.delete();
        mpkt = '0; mcnt0 = 0; mcnt1 = 0; mlast = 1'b1; mready = 1'b1;
      end else if (mready) begin
        if (dsend && ai) begin
          if (dpkt[W-1]) begin
            if (sq1.size() == 0) chk("order_ch1_extra", 64'(dpkt), 64'(0));
            else                 chk("order_ch1", 64'(dpkt), 64'(sq1.pop_front()));
          end else begin
            if (sq0.size() == 0) chk("order_ch0_extra", 64'(dpkt), 64'(0));
            else                 chk("order_ch0", 64'(dpkt), 64'(sq0.pop_front()));
          end
        end
        if (mout.size() != 0 && ai) void'(mout.pop_front());
        if (g) begin
          nxt = ch ? mb1.pop_front() : mb0.pop_front();
          mpkt = nxt;
          mout.push_back(nxt);
          mlast = ch;
          if (ch) mcnt1++;
          else    mcnt0++;
        end
        if (s0 && eack0) begin mb0.push_back(i0); sq0.push_back(i0); end
        if (s1 && eack1) begin mb1.push_back(i1); sq1.push_back(i1); end
      end
    end
  end

  task automatic do_reset();
    @(negedge CP);
    MR = 1'b1; Send_in0 = 1'b0; Send_in1 = 1'b0;
    @(negedge CP);
    MR = 1'b0;
  endtask

  initial begin
    int           seen, edges, i0, i1, ackp;
    bit           a0, a1;
    logic [W-1:0] hold;

    // Reset held for two edges.
    repeat (2) @(posedge CP);
    @(negedge CP);
    #2;
    chk("rst_send_out", 64'(Send_out), 64'(0));
    chk("rst_ack_out0", 64'(Ack_out0), 64'(1));
    chk("rst_ack_out1", 64'(Ack_out1), 64'(1));
    chk("rst_cnt0", 64'(gnt_cnt0), 64'(0));
    chk("rst_cnt1", 64'(gnt_cnt1), 64'(0));
    chk("rst_last_gnt", 64'(last_gnt), 64'(1));

    // Single packet: visible two edges after the accept.
    @(negedge CP);
    MR = 1'b0; Ack_in = 1'b1; Send_in0 = 1'b1; PACKET_IN0 = 52'h0_0003_0000_0005;
    @(negedge CP);
    Send_in0 = 1'b0;
    @(negedge CP);
    #2;
    chk("single_send", 64'(Send_out), 64'(1));
    chk("single_pkt", 64'(PACKET_OUT), 64'h0_0003_0000_0005);
    chk("single_cnt0", 64'(gnt_cnt0), 64'(1));

    // Contention: 8 tagged packets per channel, strict alternation.
    do_reset();
    Ack_in = 1'b1; i0 = 0; i1 = 0; seen = 0; edges = 0;
    forever begin
      Send_in0 = (i0 < 8); PACKET_IN0 = W'(i0);
      Send_in1 = (i1 < 8); PACKET_IN1 = {1'b1, (W-1)'(i1)};
      #1;
      a0 = Send_in0 && Ack_out0;
      a1 = Send_in1 && Ack_out1;
      if (Send_out) begin
        chk("alt_channel", 64'(PACKET_OUT[W-1]), 64'(seen % 2));
        chk("alt_tag", 64'(PACKET_OUT[7:0]), 64'(seen / 2));
        seen++;
      end
      if (seen == 16 || edges >= 40) break;
      @(negedge CP);
      edges++;
      if (a0) i0++;
      if (a1) i1++;
    end
    chk("contention_count", 64'(seen), 64'(16));
    chk("contention_cycles", 64'(edges), 64'(17));
    chk("contention_cnt0", 64'(gnt_cnt0), 64'(8));
    chk("contention_cnt1", 64'(gnt_cnt1), 64'(8));
    Send_in0 = 1'b0; Send_in1 = 1'b0;

    // Backpressure: Ack_in low for 10 cycles while both channels send.
    Ack_in = 1'b0; i0 = 100; i1 = 100;
    hold = PACKET_OUT;
    for (int k = 0; k < 10; k++) begin
      Send_in0 = 1'b1; PACKET_IN0 = W'(i0);
      Send_in1 = 1'b1; PACKET_IN1 = {1'b1, (W-1)'(i1)};
      #1;
      a0 = Ack_out0; a1 = Ack_out1;
      if (k >= 2) begin
        chk("bp_ack0_low", 64'(Ack_out0), 64'(0));
        chk("bp_ack1_low", 64'(Ack_out1), 64'(0));
      end
      if (k >= 1) begin
        chk("bp_send_held", 64'(Send_out), 64'(1));
        chk("bp_pkt_stable", 64'(PACKET_OUT), 64'(hold));
      end
      @(negedge CP);
      if (a0) i0++;
      if (a1) i1++;
    end
    Ack_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      PACKET_IN0 = W'(i0); PACKET_IN1 = {1'b1, (W-1)'(i1)};
      #1;
      a0 = Ack_out0; a1 = Ack_out1;
      @(negedge CP);
      if (a0) i0++;
      if (a1) i1++;
    end
    Send_in0 = 1'b0; Send_in1 = 1'b0;
    repeat (6) @(negedge CP);

    // Reset mid-stream with everything full.
    Ack_in = 1'b0; Send_in0 = 1'b1; Send_in1 = 1'b1;
    PACKET_IN0 = W'(200); PACKET_IN1 = {1'b1, (W-1)'(200)};
    repeat (3) @(negedge CP);
    MR = 1'b1;
    @(negedge CP);
    MR = 1'b0; Send_in0 = 1'b0; Send_in1 = 1'b0; Ack_in = 1'b1;
    #2;
    chk("mr_send_out", 64'(Send_out), 64'(0));
    chk("mr_cnt0", 64'(gnt_cnt0), 64'(0));
    chk("mr_cnt1", 64'(gnt_cnt1), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge CP);
      #2;
      chk("mr_no_stale", 64'(Send_out), 64'(0));
    end

    // Saturation: 20 ch1 packets, 4-bit counter sticks at all-ones.
    do_reset();
    Ack_in = 1'b1; i1 = 0; edges = 0;
    while (i1 < 20 && edges < 100) begin
      Send_in1 = 1'b1; PACKET_IN1 = {1'b1, (W-1)'(i1)};
      #1;
      a1 = Ack_out1;
      @(negedge CP);
      edges++;
      if (a1) i1++;
    end
    Send_in1 = 1'b0;
    repeat (4) @(negedge CP);
    #2;
    chk("sat_small_cnt1", 64'(s_cnt1), 64'hF);
    chk("sat_wide_cnt1", 64'(gnt_cnt1), 64'(20));

    // Random traffic with phases of varying downstream readiness.
    ackp = 70;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CP);
      if (c % 100 == 0) begin
        case ($urandom_range(0, 3))
          0:       ackp = 0;
          1:       ackp = 30;
          2:       ackp = 70;
          default: ackp = 100;
        endcase
      end
      MR         = ($urandom_range(0, 199) == 0);
      Send_in0   = ($urandom_range(0, 99) < 60);
      Send_in1   = ($urandom_range(0, 99) < 60);
      PACKET_IN0 = {1'b0, 51'({$urandom(), $urandom()})};
      PACKET_IN1 = {1'b1, 51'({$urandom(), $urandom()})};
      Ack_in     = ($urandom_range(0, 99) < ackp);
    end
    @(negedge CP);
    MR = 1'b0; Send_in0 = 1'b0; Send_in1 = 1'b0; Ack_in = 1'b1;
    repeat (8) @(negedge CP);
    #2;
    chk("drain_empty", 64'(Send_out), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
